// File: rtl/core_c1_defs_pkg.sv
// Shared C1 interrupt definitions: cause codes used by both the CLINT and the CSR unit,
// plus the CLINT register map.
package core_c1_defs;

  localparam logic [7:0] IRQ_CODE_MSI = 8'd3;
  localparam logic [7:0] IRQ_CODE_MTI = 8'd7;
  localparam logic [7:0] IRQ_CODE_MEI = 8'd11;

  localparam logic [4:0] CLINT_MSIP        = 5'h00;
  localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] CLINT_MTIME_LO    = 5'h0C;
  localparam logic [4:0] CLINT_MTIME_HI    = 5'h10;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MTI,
    SRC_MSI,
    SRC_MEI
  } irq_src_e;

  function automatic logic [7:0] irq_code(input irq_src_e src);
    case (src)
      SRC_MEI: irq_code = IRQ_CODE_MEI;
      SRC_MSI: irq_code = IRQ_CODE_MSI;
      default: irq_code = IRQ_CODE_MTI;
    endcase
  endfunction

endpackage

// File: rtl/core_c1_sync.sv
// Reset-to-0 multi-flop synchroniser for an asynchronous level input.
module core_c1_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/core_c1_clint.sv
// Core-local interruptor for C1: mtime/mtimecmp timer, msip, synchronised external line,
// and a fixed-priority arbiter that presents one registered request/code to the CSR unit.
module core_c1_clint
  import core_c1_defs::*;
#(
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        ext_irq,
  input  logic        int_ack,
  output logic        int_req,
  output logic [7:0]  int_code,
  output logic        mtip
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] presc_q, presc_d;
  logic        msip_q, msip_d;
  logic        int_req_q, blank_q;
  logic [7:0]  int_code_q;
  logic        ext_p;
  logic        tick;
  logic        wr;
  irq_src_e    src;

  core_c1_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ext_irq),
    .q_o   (ext_p)
  );

  assign tick = (presc_q == PRESC_MAX);
  assign wr   = reg_sel & reg_we;

  // Software writes to mtime take priority over the tick and restart the prescaler.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (reg_addr)
        CLINT_MSIP:        msip_d = reg_wdata[0];
        CLINT_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], reg_wdata};
        CLINT_MTIMECMP_HI: mtimecmp_d = {reg_wdata, mtimecmp_q[31:0]};
        CLINT_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], reg_wdata};
          presc_d = 16'd0;
        end
        CLINT_MTIME_HI: begin
          mtime_d = {reg_wdata, mtime_q[31:0]};
          presc_d = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      msip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      msip_q     <= msip_d;
    end
  end

  assign mtip = (mtime_q >= mtimecmp_q);

  always_comb begin
    if (ext_p)       src = SRC_MEI;
    else if (msip_q) src = SRC_MSI;
    else if (mtip)   src = SRC_MTI;
    else             src = SRC_NONE;
  end

  // Blank holds the request low for one cycle after a taken trap so MIE clearing can land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req_q  <= 1'b0;
      int_code_q <= 8'd0;
      blank_q    <= 1'b0;
    end else begin
      blank_q   <= int_ack & int_req_q;
      int_req_q <= (src != SRC_NONE) & ~blank_q;
      if (src != SRC_NONE) begin
        int_code_q <= irq_code(src);
      end
    end
  end

  assign int_req  = int_req_q;
  assign int_code = int_code_q;

  always_comb begin
    case (reg_addr)
      CLINT_MSIP:        reg_rdata = {31'd0, msip_q};
      CLINT_MTIMECMP_LO: reg_rdata = mtimecmp_q[31:0];
      CLINT_MTIMECMP_HI: reg_rdata = mtimecmp_q[63:32];
      CLINT_MTIME_LO:    reg_rdata = mtime_q[31:0];
      CLINT_MTIME_HI:    reg_rdata = mtime_q[63:32];
      default:           reg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_core_c1_clint.sv
// Bench for core_c1_clint: two instances (TICK_DIV=1/SYNC=2 and TICK_DIV=4/SYNC=3) on shared
// stimulus, checked every cycle against a timer/priority model plus directed literal checks.
module tb_core_c1_clint;

  localparam int DIV   [2] = '{1, 4};
  localparam int SYNCN [2] = '{2, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_sel = 1'b0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_addr = 5'h0C;
  logic [31:0] reg_wdata = 32'd0;
  logic        ext_irq = 1'b0;
  logic        int_ack = 1'b0;

  logic [31:0] rdata1, rdata4;
  logic        req1, req4, mtip1, mtip4;
  logic [7:0]  code1, code4;

  int compared = 0;
  int mismatched = 0;

  core_c1_clint #(.TICK_DIV(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(rdata1), .ext_irq(ext_irq), .int_ack(int_ack),
    .int_req(req1), .int_code(code1), .mtip(mtip1)
  );

  core_c1_clint #(.TICK_DIV(4), .SYNC_STAGES(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(rdata4), .ext_irq(ext_irq), .int_ack(int_ack),
    .int_req(req4), .int_code(code4), .mtip(mtip4)
  );

  always #5 clk = ~clk;

  // Model: mtime is the last written base plus elapsed cycles divided by the tick divisor.
  logic [63:0] mBase [2];
  logic [63:0] mCmp [2];
  int unsigned mCount [2];
  logic        mMsip [2];
  logic [2:0]  mHist [2];
  logic        mReq [2];
  logic        mBlank [2];
  logic [7:0]  mCode [2];

  logic [63:0] tNow;
  logic        pMei, pMsi, pMti, pAny, nextReq;

  function automatic logic [63:0] mTime(input int i);
    return mBase[i] + 64'(mCount[i] / DIV[i]);
  endfunction

  function automatic logic [31:0] mRead(input int i, input logic [4:0] a);
    logic [63:0] t;
    t = mTime(i);
    case (a)
      5'h00:   return {31'd0, mMsip[i]};
      5'h04:   return mCmp[i][31:0];
      5'h08:   return mCmp[i][63:32];
      5'h0C:   return t[31:0];
      5'h10:   return t[63:32];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mBase[i] = 64'd0; mCount[i] = 0; mCmp[i] = '1; mMsip[i] = 1'b0;
        mHist[i] = 3'd0; mReq[i] = 1'b0; mBlank[i] = 1'b0; mCode[i] = 8'd0;
      end else begin
        tNow = mTime(i);
        pMei = mHist[i][SYNCN[i]-1];
        pMsi = mMsip[i];
        pMti = (tNow >= mCmp[i]);
        pAny = pMei | pMsi | pMti;
        nextReq = pAny & ~mBlank[i];
        mBlank[i] = int_ack & mReq[i];
        mReq[i] = nextReq;
        if (pMei)      mCode[i] = 8'd11;
        else if (pMsi) mCode[i] = 8'd3;
        else if (pMti) mCode[i] = 8'd7;
        mHist[i] = {mHist[i][1:0], ext_irq};
        mCount[i] = mCount[i] + 1;
        if (reg_sel && reg_we) begin
          case (reg_addr)
            5'h00: mMsip[i] = reg_wdata[0];
            5'h04: mCmp[i][31:0] = reg_wdata;
            5'h08: mCmp[i][63:32] = reg_wdata;
            5'h0C: begin mBase[i] = {tNow[63:32], reg_wdata}; mCount[i] = 0; end
            5'h10: begin mBase[i] = {reg_wdata, tNow[31:0]}; mCount[i] = 0; end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("req_div1",   {31'd0, req1},  {31'd0, mReq[0]});
    checkOutput("code_div1",  {24'd0, code1}, {24'd0, mCode[0]});
    checkOutput("mtip_div1",  {31'd0, mtip1}, {31'd0, mTime(0) >= mCmp[0]});
    checkOutput("rdata_div1", rdata1,         mRead(0, reg_addr));
    checkOutput("req_div4",   {31'd0, req4},  {31'd0, mReq[1]});
    checkOutput("code_div4",  {24'd0, code4}, {24'd0, mCode[1]});
    checkOutput("mtip_div4",  {31'd0, mtip4}, {31'd0, mTime(1) >= mCmp[1]});
    checkOutput("rdata_div4", rdata4,         mRead(1, reg_addr));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cyc(1);
    reg_sel = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b1;
    reg_addr = 5'h0C;
    @(negedge clk); checkOutput("lit_mtime0", rdata1, 32'd0);
    @(negedge clk); checkOutput("lit_mtime1", rdata1, 32'd1);
    @(negedge clk); checkOutput("lit_mtime2", rdata1, 32'd2);
    checkOutput("lit_mtime_div4", rdata4, 32'd0);
    cyc(1); reg_addr = 5'h04;
    @(negedge clk); checkOutput("lit_cmp_lo_rst", rdata1, 32'hFFFF_FFFF);
    cyc(1); reg_addr = 5'h08;
    @(negedge clk); checkOutput("lit_cmp_hi_rst", rdata1, 32'hFFFF_FFFF);
    checkOutput("lit_req_rst", {31'd0, req1}, 32'd0);
    cyc(1); reg_addr = 5'h14;
    cyc(1);

    // Timer interrupt at mtime == 10, then cleared by moving mtimecmp out of reach.
    applyStimulus(5'h0C, 32'd0);
    applyStimulus(5'h08, 32'd0);
    applyStimulus(5'h04, 32'd10);
    cyc(7);
    @(negedge clk); checkOutput("lit_mtip_before", {31'd0, mtip1}, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_mtip_at10", {31'd0, mtip1}, 32'd1);
    checkOutput("lit_req_lag", {31'd0, req1}, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_req_mti", {31'd0, req1}, 32'd1);
    checkOutput("lit_code_mti", {24'd0, code1}, 32'd7);
    cyc(1);
    applyStimulus(5'h04, 32'hFFFF_FFFF);
    @(negedge clk); checkOutput("lit_mtip_drop", {31'd0, mtip1}, 32'd0);
    checkOutput("lit_req_hold", {31'd0, req1}, 32'd1);
    cyc(1);
    @(negedge clk); checkOutput("lit_req_drop", {31'd0, req1}, 32'd0);
    cyc(1);
    applyStimulus(5'h08, 32'hFFFF_FFFF);

    // MSI preempts MTI, ack blanks one cycle, msip clear falls back to MTI.
    applyStimulus(5'h08, 32'd0);
    applyStimulus(5'h04, 32'd0);
    cyc(2);
    applyStimulus(5'h00, 32'hFFFF_FFFF);
    reg_addr = 5'h00;
    @(negedge clk); checkOutput("lit_code_still7", {24'd0, code1}, 32'd7);
    checkOutput("lit_msip_read", rdata1, 32'd1);
    cyc(1);
    @(negedge clk); checkOutput("lit_code_msi", {24'd0, code1}, 32'd3);
    checkOutput("lit_req_held", {31'd0, req1}, 32'd1);
    cyc(1);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    @(negedge clk); checkOutput("lit_req_after_ack", {31'd0, req1}, 32'd1);
    cyc(1);
    @(negedge clk); checkOutput("lit_req_blank", {31'd0, req1}, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_req_again", {31'd0, req1}, 32'd1);
    checkOutput("lit_code_again", {24'd0, code1}, 32'd3);
    applyStimulus(5'h00, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_code_back7", {24'd0, code1}, 32'd7);

    // External interrupt beats msip after the synchroniser latency.
    applyStimulus(5'h00, 32'd1);
    cyc(2);
    ext_irq = 1'b1;
    cyc(2);
    @(negedge clk); checkOutput("lit_code_pre_mei", {24'd0, code1}, 32'd3);
    cyc(1);
    @(negedge clk); checkOutput("lit_code_mei", {24'd0, code1}, 32'd11);
    cyc(2);
    ext_irq = 1'b0;
    cyc(2);
    @(negedge clk); checkOutput("lit_code_mei_hold", {24'd0, code1}, 32'd11);
    cyc(1);
    @(negedge clk); checkOutput("lit_code_msi_back", {24'd0, code1}, 32'd3);
    cyc(3);
    applyStimulus(5'h00, 32'd0);
    applyStimulus(5'h04, 32'hFFFF_FFFF);
    applyStimulus(5'h08, 32'hFFFF_FFFF);
    cyc(2);

    // Divided timer: carry from lo to hi, then a write landing on a tick wins.
    applyStimulus(5'h0C, 32'hFFFF_FFFF);
    applyStimulus(5'h10, 32'd0);
    reg_addr = 5'h10;
    cyc(3);
    @(negedge clk); checkOutput("lit_div4_hi_pre", rdata4, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_div4_hi_carry", rdata4, 32'd1);
    cyc(1); reg_addr = 5'h0C;
    @(negedge clk); checkOutput("lit_div4_lo_wrap", rdata4, 32'd0);
    cyc(2);
    applyStimulus(5'h0C, 32'h0000_1234);
    @(negedge clk); checkOutput("lit_div4_tick_write", rdata4, 32'h0000_1234);
    cyc(5);

    // Asynchronous reset mid-request, then an ack with no request must not blank.
    applyStimulus(5'h00, 32'd1);
    cyc(2);
    rst_n = 1'b0;
    reg_addr = 5'h04;
    #1;
    checkOutput("lit_async_req", {31'd0, req1}, 32'd0);
    checkOutput("lit_async_cmp", rdata1, 32'hFFFF_FFFF);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    int_ack = 1'b1;
    applyStimulus(5'h00, 32'd1);
    int_ack = 1'b0;
    @(negedge clk); checkOutput("lit_noblank_lag", {31'd0, req1}, 32'd0);
    cyc(1);
    @(negedge clk); checkOutput("lit_noblank_req", {31'd0, req1}, 32'd1);
    checkOutput("lit_noblank_code", {24'd0, code1}, 32'd3);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core_c1_clint.md
Name: core_c1_clint

Overview:
Core-local interrupt source for the C1 RV32I core; drives the interrupt-request side of the CSR unit's interrupt inputs (in_interrupt, in_interrupt_code).
Holds a 64-bit mtime counter, a 64-bit mtimecmp, the msip bit, and a synchronised external interrupt line.
Arbitrates pending machine interrupts by fixed priority and presents one registered request and code.
Software accesses the registers through a simple single-cycle register port on the SoC bus.

Parameters:
TICK_DIV, 1, mtime increments once every TICK_DIV clk cycles (1..65535); 1 means every cycle.
SYNC_STAGES, 2, flip-flop stages on ext_irq (2..3).

Ports:
clk  input  1  core clock.
rst_n  input  1  asynchronous active-low reset.
reg_sel  input  1  register port access strobe, single cycle.
reg_we  input  1  1 = write, 0 = read; qualified by reg_sel.
reg_addr  input  5  byte offset: 0x00 msip, 0x04 mtimecmp_lo, 0x08 mtimecmp_hi, 0x0C mtime_lo, 0x10 mtime_hi.
reg_wdata  input  32  write data.
reg_rdata  output  32  read data; combinational from reg_addr; 0 for unmapped offsets.
ext_irq  input  1  asynchronous level external interrupt (PLIC/GPIO), active-high.
int_ack  input  1  core took the trap this cycle (the CSR unit's pc_wash_req_e qualified by not-mret).
int_req  output  1  request to the CSR unit (in_interrupt).
int_code  output  8  cause code to the CSR unit (in_interrupt_code): 11, 3 or 7.
mtip  output  1  raw timer-pending level, exported for debug and mip visibility.

Behaviour:
- Reset (async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, sync chain=0, int_req=0, int_code=0, blank=0, mtip=0.
- Prescaler: counts 0..TICK_DIV-1. mtime+=1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0. mtime is a 64-bit wrap-around counter (all-ones+1 gives 0).
- Writes (reg_sel&reg_we): 32-bit half writes only. A write to mtime_lo or mtime_hi overrides the increment in that cycle: the written half takes reg_wdata, the other half holds its value, and there is no carry. The prescaler resets to 0 on any mtime write.
- msip = reg_wdata[0]; msip bits 31:1 read as 0.
- mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from the registers.
- ext_p = last stage of the ext_irq synchroniser. Latency from ext_irq rising to ext_p is SYNC_STAGES cycles.
- Pending set: MEI=ext_p, MSI=msip, MTI=mtip. All are levels and are not latched. Software clears them at the source: msip write 0, new mtimecmp, device deassert.
- Priority (high to low): MEI (code 11) > MSI (code 3) > MTI (code 7).
- Output register, updated every cycle: int_req <= any_pending & ~blank; int_code <= code of the highest pending source. When nothing is pending, int_code holds its last value. Latency is 1 cycle from pending to int_req.
- Blanking: int_ack=1 sets blank for exactly the next cycle, which forces int_req=0 on the following edge. This lets the CSR unit's MIE clear propagate before re-presentation. int_ack while int_req=0 is ignored (no blank).
- Simultaneous pending sources: only the winner is presented. Losers stay pending and are presented after the winner clears or after the next ack/blank cycle.
- Priority change while int_req=1 (higher source arrives): int_code switches to the higher code on the next edge, and int_req stays 1.
- A write to mtimecmp that makes mtime < mtimecmp drops mtip in the same cycle; int_req drops one cycle later.
- Reset mid-operation: all state returns to reset values immediately, and int_req falls asynchronously.

Decomposition:
- Shared package/include core_c1_defs: interrupt codes IRQ_CODE_MSI=8'd3, IRQ_CODE_MTI=8'd7, IRQ_CODE_MEI=8'd11; CLINT register offsets.
- The CSR unit reuses the same code constants.
- One sub-module: core_c1_sync (SYNC_STAGES-deep reset-to-0 synchroniser) for ext_irq.
- Timer, register port and arbiter stay in the top level.

Test Plan:
1. Reset, TICK_DIV=1: mtime reads 0,1,2… on consecutive cycles. mtimecmp_lo/hi read 0xFFFFFFFF. int_req=0.
2. Write mtimecmp_hi=0, mtimecmp_lo=10 with mtime=0 -> mtip rises when mtime=10. int_req=1 and int_code=7 one cycle later. Writing mtimecmp_lo=0xFFFFFFFF (hi=0xFFFFFFFF) -> int_req=0 one cycle later.
3. Write msip=1 while MTI is pending -> int_code switches 7→3 next edge with int_req held 1. Pulse int_ack -> int_req=0 for one cycle, then 1 again with code 3. Write msip=0 -> code 7 is presented.
4. Raise ext_irq with msip=1 -> after SYNC_STAGES+1 cycles int_code=11. Deassert ext_irq -> int_code=3.
5. TICK_DIV=4: mtime increments every 4th cycle. Writing mtime_lo=0xFFFFFFFF, mtime_hi=0 -> the next tick gives mtime_hi=1, mtime_lo=0. A write coinciding with a tick leaves mtime equal to the written value.
6. Assert rst_n low mid-request -> int_req=0 immediately and all registers return to reset values. int_ack with int_req=0 -> no blank cycle is observed.
